mem_port_arbiter: RTL and testbench

- Shares one single-ported MainMemoryModule between the instruction-fetch requester (program counter side) and the data requester (ALU address / load-store side).
- Arbitrates between the two, sequences read latency and routes read data back to the owning requester.
- Uses data-first priority with a bounded-starvation guarantee for fetch.
- Sits between the cpu datapath and a unified memory; the cpu stalls on any request that has not yet been granted.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM encoding,
// requester ids and a helper for sizing counters from their maximum value.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_IF = 1'b0;
  localparam req_id_t REQ_D  = 1'b1;

  localparam int RD_LAT_MAX     = 7;
  localparam int STARVE_MAX_MAX = 15;

  // Bits needed to hold any value in 0..maxVal (at least one bit).
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data has priority unless fetch has already
// lost STARVE_MAX consecutive arbitrations.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SCW        = cntWidth(STARVE_MAX)
) (
  input  logic           ifReq_i,
  input  logic           dReq_i,
  input  logic [SCW-1:0] starveCnt_i,
  output logic           grant_o,
  output req_id_t        winner_o
);

  logic starved;

  assign starved = (starveCnt_i == SCW'(STARVE_MAX));

  always_comb begin
    grant_o  = ifReq_i | dReq_i;
    winner_o = REQ_IF;
    if (dReq_i && !(ifReq_i && starved)) begin
      winner_o = REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// sequencing read latency and returning read data to the requester that owns it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int LCW = cntWidth(RD_LAT);
  localparam int SCW = cntWidth(STARVE_MAX);

  arb_state_e     stateQ, stateD;
  logic [LCW-1:0] latCntQ, latCntD;
  logic [SCW-1:0] starveCntQ, starveCntD;
  req_id_t        ownerQ, ownerD;

  logic    pickValid;
  req_id_t pickWinner;
  logic    readDone;
  logic    arbOpen;
  logic    grantIf;
  logic    grantD;
  logic    grantRead;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX),
    .SCW       (SCW)
  ) u_pick (
    .ifReq_i    (if_req),
    .dReq_i     (d_req),
    .starveCnt_i(starveCntQ),
    .grant_o    (pickValid),
    .winner_o   (pickWinner)
  );

  // The memory is free in IDLE or in the last WAIT cycle; rst is active-low,
  // so grants are held off while it is low even though the inputs may request.
  assign readDone  = (stateQ == WAIT) && (latCntQ == LCW'(1));
  assign arbOpen   = rst && ((stateQ == IDLE) || readDone);
  assign grantIf   = arbOpen && pickValid && (pickWinner == REQ_IF);
  assign grantD    = arbOpen && pickValid && (pickWinner == REQ_D);
  assign grantRead = grantIf || (grantD && !d_we);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ     <= IDLE;
      latCntQ    <= '0;
      starveCntQ <= '0;
      ownerQ     <= REQ_IF;
    end else begin
      stateQ     <= stateD;
      latCntQ    <= latCntD;
      starveCntQ <= starveCntD;
      ownerQ     <= ownerD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    latCntD    = latCntQ;
    starveCntD = starveCntQ;
    ownerD     = ownerQ;

    case (stateQ)
      IDLE: begin
        if (grantRead) begin
          stateD = WAIT;
        end
      end
      WAIT: begin
        if (readDone) begin
          stateD = grantRead ? WAIT : IDLE;
        end
      end
      default: stateD = IDLE;
    endcase

    if (stateQ == WAIT) begin
      latCntD = latCntQ - LCW'(1);
    end
    if (grantRead) begin
      latCntD = LCW'(RD_LAT);
      ownerD  = grantIf ? REQ_IF : REQ_D;
    end

    // Counts data wins that leave a fetch waiting; any fetch win or idle fetch resets it.
    if (!if_req || grantIf) begin
      starveCntD = '0;
    end else if (grantD && (starveCntQ != SCW'(STARVE_MAX))) begin
      starveCntD = starveCntQ + SCW'(1);
    end
  end

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;

    if (grantD) begin
      d_gnt    = 1'b1;
      mem_addr = d_addr;
      mem_re   = !d_we;
      mem_we   = d_we;
      if (d_we) begin
        mem_wdata = d_wdata;
      end
    end else if (grantIf) begin
      if_gnt   = 1'b1;
      mem_addr = if_addr;
      mem_re   = 1'b1;
    end

    if (readDone) begin
      if (ownerQ == REQ_IF) begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end else begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (RD_LAT 1..3) share stimulus;
// a negedge monitor scoreboards read data of the instance selected by 'sel'.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NINST = 3;

  typedef struct {
    logic          isD;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ifReq;
  logic [AW-1:0] ifAddr;
  logic          dReq;
  logic          dWe;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dWdata;

  logic [NINST-1:0] ifGnt, ifRvalid, dGnt, dRvalid, memRe, memWe;
  logic [DW-1:0]    ifRdata  [NINST];
  logic [DW-1:0]    dRdata   [NINST];
  logic [DW-1:0]    memWdata [NINST];
  logic [DW-1:0]    memRdata [NINST];
  logic [AW-1:0]    memAddr  [NINST];

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   cycle   = 0;
  int   sel     = 0;

  function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'h8C220004;
    return 32'hA500_0000 ^ (a * 32'h0001_0003);
  endfunction

  for (genvar g = 0; g < NINST; g++) begin : gInst
    logic [DW-1:0] pipe [8];

    mem_port_arbiter #(
      .AW(AW), .DW(DW), .RD_LAT(g + 1), .STARVE_MAX(4)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (ifReq),
      .if_addr  (ifAddr),
      .if_gnt   (ifGnt[g]),
      .if_rvalid(ifRvalid[g]),
      .if_rdata (ifRdata[g]),
      .d_req    (dReq),
      .d_we     (dWe),
      .d_addr   (dAddr),
      .d_wdata  (dWdata),
      .d_gnt    (dGnt[g]),
      .d_rvalid (dRvalid[g]),
      .d_rdata  (dRdata[g]),
      .mem_addr (memAddr[g]),
      .mem_re   (memRe[g]),
      .mem_we   (memWe[g]),
      .mem_wdata(memWdata[g]),
      .mem_rdata(memRdata[g])
    );

    // Memory model: read data appears g+1 cycles after mem_re, garbage otherwise.
    always @(posedge clk) begin
      pipe[0] <= memRe[g] ? memData(memAddr[g]) : 32'hFFFF_FFFF;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign memRdata[g] = pipe[g];
  end

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Scoreboard and protocol monitor for the selected instance.
  initial begin : monitor
    logic          ifPendQ, dPendQ, dWeQ;
    logic [AW-1:0] ifAddrQ, dAddrQ;
    logic [DW-1:0] dWdataQ, actData, otherData;
    exp_t          e;
    ifPendQ = 1'b0;
    dPendQ  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ifPendQ = 1'b0;
        dPendQ  = 1'b0;
      end else begin
        if (ifPendQ) begin
          nChecks++;
          if (ifReq !== 1'b1 || ifAddr !== ifAddrQ) begin
            nFails++;
            $display("[TB] FAIL protocol_if: req=%b addr=%h, required req=1 addr=%h", ifReq, ifAddr, ifAddrQ);
          end
        end
        if (dPendQ) begin
          nChecks++;
          if (dReq !== 1'b1 || dAddr !== dAddrQ || dWe !== dWeQ || dWdata !== dWdataQ) begin
            nFails++;
            $display("[TB] FAIL protocol_d: req=%b addr=%h we=%b, required req=1 addr=%h we=%b", dReq, dAddr, dWe, dAddrQ, dWeQ);
          end
        end

        if (ifRvalid[sel] || dRvalid[sel]) begin
          nChecks++;
          if (sbQ.size() == 0) begin
            nFails++;
            $display("[TB] FAIL unexpected_rvalid: if_rvalid=%b d_rvalid=%b at cycle %0d, required none", ifRvalid[sel], dRvalid[sel], cycle);
          end else begin
            e         = sbQ.pop_front();
            actData   = dRvalid[sel] ? dRdata[sel] : ifRdata[sel];
            otherData = dRvalid[sel] ? ifRdata[sel] : dRdata[sel];
            if ((ifRvalid[sel] && dRvalid[sel]) || dRvalid[sel] !== e.isD || actData !== e.data ||
                otherData !== '0 || cycle !== e.due) begin
              nFails++;
              $display("[TB] FAIL read_return: isD=%b data=%h other=%h cycle=%0d, required isD=%b data=%h other=0 cycle=%0d",
                       dRvalid[sel], actData, otherData, cycle, e.isD, e.data, e.due);
            end
          end
        end else if (sbQ.size() > 0 && sbQ[0].due <= cycle) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL missing_rvalid: no rvalid at cycle %0d, required isD=%b data=%h", cycle, sbQ[0].isD, sbQ[0].data);
          void'(sbQ.pop_front());
        end

        if (ifGnt[sel]) sbQ.push_back(exp_t'{isD: 1'b0, data: memData(ifAddr), due: cycle + sel + 1});
        if (dGnt[sel] && !dWe) sbQ.push_back(exp_t'{isD: 1'b1, data: memData(dAddr), due: cycle + sel + 1});

        ifPendQ = ifReq && !ifGnt[sel];
        dPendQ  = dReq && !dGnt[sel];
        ifAddrQ = ifAddr;
        dAddrQ  = dAddr;
        dWeQ    = dWe;
        dWdataQ = dWdata;
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyIdle(input int n);
    ifReq = 1'b0;
    dReq  = 1'b0;
    dWe   = 1'b0;
    repeat (n) nextCycle();
  endtask

  task automatic waitGrant(input bit wantD, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = wantD ? dGnt[sel] : ifGnt[sel];
    end
  endtask

  task automatic test_reset();
    bit ok;
    sel    = 0;
    rst    = 1'b0;
    ifReq  = 1'b1;
    dReq   = 1'b1;
    dWe    = 1'b0;
    ifAddr = 32'h100;
    dAddr  = 32'h200;
    dWdata = '0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NINST; g++) begin
      nChecks++;
      if ({ifGnt[g], dGnt[g], ifRvalid[g], dRvalid[g], memRe[g], memWe[g]} !== 6'b0 ||
          memAddr[g] !== '0 || memWdata[g] !== '0 || ifRdata[g] !== '0 || dRdata[g] !== '0) begin
        nFails++;
        $display("[TB] FAIL reset_outputs[%0d]: gnt/rv/re/we=%b addr=%h wdata=%h, required all 0", g,
                 {ifGnt[g], dGnt[g], ifRvalid[g], dRvalid[g], memRe[g], memWe[g]}, memAddr[g], memWdata[g]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    nChecks++;
    if (dGnt[0] !== 1'b1 || ifGnt[0] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL first_grant: d_gnt=%b if_gnt=%b, required d_gnt=1 if_gnt=0", dGnt[0], ifGnt[0]);
    end
    nextCycle();
    dReq = 1'b0;
    waitGrant(1'b0, 4, ok);
    nChecks++;
    if (!ok) begin
      nFails++;
      $display("[TB] FAIL reset_fetch_grant: if_gnt=0 within 4 cycles, required 1");
    end
    nextCycle();
    applyIdle(6);
  endtask

  task automatic test_fetch_read();
    sel    = 0;
    ifReq  = 1'b1;
    ifAddr = 32'h10;
    @(negedge clk);
    nChecks++;
    if ({ifGnt[0], dGnt[0], memRe[0], memWe[0]} !== 4'b1010 || memAddr[0] !== 32'h10) begin
      nFails++;
      $display("[TB] FAIL fetch_grant: if_gnt/d_gnt/re/we=%b addr=%h, required 1010 addr=00000010",
               {ifGnt[0], dGnt[0], memRe[0], memWe[0]}, memAddr[0]);
    end
    nextCycle();
    ifReq = 1'b0;
    @(negedge clk);
    nChecks++;
    if (ifRvalid[0] !== 1'b1 || ifRdata[0] !== 32'h8C220004) begin
      nFails++;
      $display("[TB] FAIL fetch_data: if_rvalid=%b if_rdata=%h, required 1 8c220004", ifRvalid[0], ifRdata[0]);
    end
    nChecks++;
    if (dRvalid[0] !== 1'b0 || dRdata[0] !== '0) begin
      nFails++;
      $display("[TB] FAIL fetch_d_quiet: d_rvalid=%b d_rdata=%h, required 0 0", dRvalid[0], dRdata[0]);
    end
    nextCycle();
    applyIdle(3);
  endtask

  task automatic test_simultaneous();
    sel = 1;
    applyIdle(4);
    dReq   = 1'b1;
    dWe    = 1'b0;
    dAddr  = 32'h40;
    ifReq  = 1'b1;
    ifAddr = 32'h14;
    @(negedge clk);
    nChecks++;
    if (dGnt[1] !== 1'b1 || ifGnt[1] !== 1'b0 || memAddr[1] !== 32'h40 || memRe[1] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL simul_d_grant: d_gnt=%b if_gnt=%b addr=%h re=%b, required 1 0 00000040 1", dGnt[1], ifGnt[1], memAddr[1], memRe[1]);
    end
    nextCycle();
    dReq = 1'b0;
    @(negedge clk);
    nChecks++;
    if (ifGnt[1] !== 1'b0 || memRe[1] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL simul_wait_hold: if_gnt=%b re=%b, required 0 0", ifGnt[1], memRe[1]);
    end
    nextCycle();
    @(negedge clk);
    nChecks++;
    if (dRvalid[1] !== 1'b1 || dRdata[1] !== memData(32'h40) || ifGnt[1] !== 1'b1 || memAddr[1] !== 32'h14) begin
      nFails++;
      $display("[TB] FAIL simul_handover: d_rvalid=%b d_rdata=%h if_gnt=%b addr=%h, required 1 %h 1 00000014",
               dRvalid[1], dRdata[1], ifGnt[1], memAddr[1], memData(32'h40));
    end
    nextCycle();
    ifReq = 1'b0;
    @(negedge clk);
    nChecks++;
    if (ifRvalid[1] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL simul_if_early: if_rvalid=%b, required 0", ifRvalid[1]);
    end
    nextCycle();
    @(negedge clk);
    nChecks++;
    if (ifRvalid[1] !== 1'b1 || ifRdata[1] !== memData(32'h14)) begin
      nFails++;
      $display("[TB] FAIL simul_if_data: if_rvalid=%b if_rdata=%h, required 1 %h", ifRvalid[1], ifRdata[1], memData(32'h14));
    end
    nextCycle();
    applyIdle(4);
  endtask

  task automatic test_starvation();
    bit expD [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int got;
    bit wasD, seen, ok;
    sel = 0;
    applyIdle(2);
    ifReq  = 1'b1;
    dReq   = 1'b1;
    dWe    = 1'b0;
    ifAddr = 32'h300;
    dAddr  = 32'h400;
    got    = 0;
    for (int c = 0; c < 60 && got < 11; c++) begin
      @(negedge clk);
      seen = ifGnt[0] || dGnt[0];
      wasD = dGnt[0];
      if (seen) begin
        nChecks++;
        if ((ifGnt[0] && dGnt[0]) || dGnt[0] !== expD[got]) begin
          nFails++;
          $display("[TB] FAIL starve_order[%0d]: d_gnt=%b if_gnt=%b, required d_gnt=%b", got, dGnt[0], ifGnt[0], expD[got]);
        end
        got++;
      end
      nextCycle();
      if (seen && wasD) dAddr = dAddr + 32'h4;
      if (seen && !wasD) ifAddr = ifAddr + 32'h4;
    end
    nChecks++;
    if (got != 11) begin
      nFails++;
      $display("[TB] FAIL starve_count: %0d grants seen, required 11", got);
    end
    dReq = 1'b0;
    waitGrant(1'b0, 6, ok);
    nChecks++;
    if (!ok) begin
      nFails++;
      $display("[TB] FAIL starve_final_fetch: if_gnt=0 within 6 cycles, required 1");
    end
    nextCycle();
    applyIdle(3);
  endtask

  task automatic test_data_write();
    sel    = 0;
    dReq   = 1'b1;
    dWe    = 1'b1;
    dAddr  = 32'h40;
    dWdata = 32'hDEADBEEF;
    ifReq  = 1'b1;
    ifAddr = 32'h20;
    @(negedge clk);
    nChecks++;
    if ({dGnt[0], ifGnt[0], memWe[0], memRe[0]} !== 4'b1010 || memAddr[0] !== 32'h40 || memWdata[0] !== 32'hDEADBEEF) begin
      nFails++;
      $display("[TB] FAIL write_grant: d_gnt/if_gnt/we/re=%b addr=%h wdata=%h, required 1010 00000040 deadbeef",
               {dGnt[0], ifGnt[0], memWe[0], memRe[0]}, memAddr[0], memWdata[0]);
    end
    nextCycle();
    dReq   = 1'b0;
    dWe    = 1'b0;
    dWdata = '0;
    @(negedge clk);
    nChecks++;
    if ({ifGnt[0], memRe[0], memWe[0], dRvalid[0]} !== 4'b1100 || memAddr[0] !== 32'h20 || memWdata[0] !== '0) begin
      nFails++;
      $display("[TB] FAIL write_then_fetch: if_gnt/re/we/d_rvalid=%b addr=%h wdata=%h, required 1100 00000020 0",
               {ifGnt[0], memRe[0], memWe[0], dRvalid[0]}, memAddr[0], memWdata[0]);
    end
    nextCycle();
    ifReq = 1'b0;
    @(negedge clk);
    nChecks++;
    if (dRvalid[0] !== 1'b0 || ifRvalid[0] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL write_no_rvalid: d_rvalid=%b if_rvalid=%b, required 0 1", dRvalid[0], ifRvalid[0]);
    end
    nextCycle();
    applyIdle(3);
  endtask

  task automatic test_back_to_back();
    int gntCyc [3];
    int got;
    sel = 1;
    applyIdle(4);
    dReq  = 1'b1;
    dWe   = 1'b0;
    dAddr = 32'h500;
    got   = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      @(negedge clk);
      if (dGnt[1]) begin
        gntCyc[got] = c;
        got++;
      end
      nextCycle();
      if (got > 0 && gntCyc[got-1] == c) begin
        dAddr = dAddr + 32'h4;
        if (got == 3) dReq = 1'b0;
      end
    end
    nChecks++;
    if (got != 3 || gntCyc[0] != 0 || gntCyc[1] != 2 || gntCyc[2] != 4) begin
      nFails++;
      $display("[TB] FAIL back_to_back: %0d grants at %0d/%0d/%0d, required 3 at 0/2/4", got, gntCyc[0], gntCyc[1], gntCyc[2]);
    end
    dReq = 1'b0;
    applyIdle(5);
  endtask

  task automatic test_reset_mid_read();
    int hits;
    sel = 2;
    applyIdle(4);
    dReq  = 1'b1;
    dWe   = 1'b0;
    dAddr = 32'h80;
    @(negedge clk);
    nChecks++;
    if (dGnt[2] !== 1'b1 || memRe[2] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL midrst_grant: d_gnt=%b re=%b, required 1 1", dGnt[2], memRe[2]);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    dReq = 1'b0;
    sbQ.delete();
    repeat (2) nextCycle();
    rst    = 1'b1;
    ifReq  = 1'b1;
    ifAddr = 32'h24;
    @(negedge clk);
    nChecks++;
    if (ifGnt[2] !== 1'b1 || memAddr[2] !== 32'h24) begin
      nFails++;
      $display("[TB] FAIL midrst_regrant: if_gnt=%b addr=%h, required 1 00000024", ifGnt[2], memAddr[2]);
    end
    nextCycle();
    ifReq = 1'b0;
    hits  = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (dRvalid[2]) hits++;
    end
    nChecks++;
    if (hits != 0) begin
      nFails++;
      $display("[TB] FAIL midrst_no_rvalid: d_rvalid seen %0d times, required 0", hits);
    end
    nextCycle();
    applyIdle(2);
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_starvation();
    test_data_write();
    test_back_to_back();
    test_reset_mid_read();
    applyIdle(4);
    nChecks++;
    if (sbQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL sb_drain: %0d reads outstanding, required 0", sbQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
